// File: rtl/rsa_modexp_ctrl.sv
// Control sequencer for a Montgomery modular-exponentiation datapath:
// entry conversion, right-to-left exponent scan, exit conversion, one-cycle eoc.
module rsa_modexp_ctrl #(
  parameter int EXP_W      = 8,
  parameter int MMM_LAT    = 11,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_e,
  output logic             busy,
  output logic             rst_mmm,
  output logic             ld_a,
  output logic             ld_r,
  output logic             lock1,
  output logic             lock2,
  output logic [1:0]       sel1,
  output logic             sel2,
  output logic             eoc
);

  localparam int PH_W = $clog2(MMM_LAT + 1);
  localparam int BC_W = $clog2(EXP_W + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(MMM_LAT);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(EXP_W - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ITER = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             ph_last_s;
  logic             iter_exit_s;

  assign ph_last_s   = (ph_q == PH_LAST);
  assign iter_exit_s = (bc_q == BC_LAST) ||
                       ((EARLY_EXIT != 0) && ((e_q >> 1) == '0));

  // State, phase, bit-counter and exponent register; en gates every update
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bc_q    <= '0;
      e_q     <= '0;
    end else if (en) begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bc_q    <= bc_d;
      e_q     <= e_d;
    end else begin
      state_q <= state_q;
      ph_q    <= ph_q;
      bc_q    <= bc_q;
      e_q     <= e_q;
    end
  end

  // Next-state logic; ph clears on every state entry and ITER restart
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bc_d    = bc_q;
    e_d     = e_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          e_d     = exp_e;
          bc_d    = '0;
          ph_d    = '0;
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (ph_last_s) begin
          ph_d    = '0;
          state_d = ((EARLY_EXIT != 0) && (e_q == '0)) ? S_POST : S_ITER;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_ITER: begin
        if (ph_last_s) begin
          ph_d = '0;
          e_d  = e_q >> 1;
          bc_d = bc_q + BC_W'(1);
          if (iter_exit_s) begin
            state_d = S_POST;
          end else begin
            state_d = S_ITER;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_POST: begin
        if (ph_last_s) begin
          ph_d    = '0;
          state_d = S_DONE;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = '0;
        bc_d    = '0;
        e_d     = '0;
      end
    endcase
  end

  // Moore output decode of state, ph and e[0]
  always_comb begin
    busy    = 1'b0;
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b1;
    lock2   = 1'b1;
    sel1    = 2'b00;
    sel2    = 1'b0;
    eoc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_PRE: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (ph_q == '0);
        ld_r    = ph_last_s;
      end
      S_ITER: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (ph_q == '0);
        ld_r    = ph_last_s;
        lock1   = e_q[0];
        sel1    = 2'b01;
        sel2    = 1'b1;
      end
      S_POST: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        ld_a    = (ph_q == '0);
        ld_r    = ph_last_s;
        lock2   = 1'b0;
        sel1    = 2'b10;
        sel2    = 1'b1;
      end
      S_DONE: begin
        busy    = 1'b1;
        rst_mmm = 1'b1;
        lock2   = 1'b0;
        sel1    = 2'b10;
        sel2    = 1'b1;
        eoc     = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: three configurations (defaults, early exit, 4-bit/lat-4)
// checked by a per-run scoreboard of latency, pulse counts and lock1 sequence.
module tb_rsa_modexp_ctrl;

  typedef struct {
    int          dut;
    int          cyc;
    int          nld;
    int          nit;
    logic [15:0] seq;
  } exp_t;

  logic       clk;
  logic       rstb;
  logic [2:0] en_s;
  logic [2:0] start_s;
  logic [7:0] exp0_s;
  logic [7:0] exp1_s;
  logic [3:0] exp2_s;
  logic [2:0] busy_w, rst_mmm_w, ld_a_w, ld_r_w, lock1_w, lock2_w, sel2_w, eoc_w;
  logic [1:0] sel1_w [3];
  logic [9:0] sig [3];

  exp_t sbq[$];
  int   total;
  int   bad;

  bit          active   [3];
  bit          had_prev [3];
  logic        prev_en  [3];
  logic [9:0]  prev_sig [3];
  int          cyc      [3];
  int          nlda     [3];
  int          nldr     [3];
  int          nit      [3];
  int          last_lda [3];
  logic [15:0] seq      [3];

  rsa_modexp_ctrl u_def (
    .clk(clk), .rstb(rstb), .en(en_s[0]), .start(start_s[0]), .exp_e(exp0_s),
    .busy(busy_w[0]), .rst_mmm(rst_mmm_w[0]), .ld_a(ld_a_w[0]), .ld_r(ld_r_w[0]),
    .lock1(lock1_w[0]), .lock2(lock2_w[0]), .sel1(sel1_w[0]), .sel2(sel2_w[0]), .eoc(eoc_w[0])
  );

  rsa_modexp_ctrl #(.EXP_W(8), .MMM_LAT(11), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rstb(rstb), .en(en_s[1]), .start(start_s[1]), .exp_e(exp1_s),
    .busy(busy_w[1]), .rst_mmm(rst_mmm_w[1]), .ld_a(ld_a_w[1]), .ld_r(ld_r_w[1]),
    .lock1(lock1_w[1]), .lock2(lock2_w[1]), .sel1(sel1_w[1]), .sel2(sel2_w[1]), .eoc(eoc_w[1])
  );

  rsa_modexp_ctrl #(.EXP_W(4), .MMM_LAT(4), .EARLY_EXIT(0)) u_small (
    .clk(clk), .rstb(rstb), .en(en_s[2]), .start(start_s[2]), .exp_e(exp2_s),
    .busy(busy_w[2]), .rst_mmm(rst_mmm_w[2]), .ld_a(ld_a_w[2]), .ld_r(ld_r_w[2]),
    .lock1(lock1_w[2]), .lock2(lock2_w[2]), .sel1(sel1_w[2]), .sel2(sel2_w[2]), .eoc(eoc_w[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_sig
    assign sig[g] = {busy_w[g], rst_mmm_w[g], ld_a_w[g], ld_r_w[g], lock1_w[g],
                     lock2_w[g], sel1_w[g], sel2_w[g], eoc_w[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 2) ? 4 : 11;
  endfunction

  // Reference model of one run: N passes, latency, pulse counts, lock1 bits
  function automatic exp_t model(int k, logic [7:0] e);
    exp_t r;
    int   n;
    n = (k == 2) ? 4 : 8;
    if (k == 1) begin
      n = 0;
      for (int i = 0; i < 8; i++) if (e[i]) n = i + 1;
    end
    r.dut = k;
    r.cyc = (n + 2) * (lat_of(k) + 1) + 1;
    r.nld = n + 2;
    r.nit = n;
    r.seq = {8'h00, e} & ((16'd1 << n) - 16'd1);
    return r;
  endfunction

  // Output monitor: counts enabled cycles per run, checks en=0 freezes, pops on eoc
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rstb) begin
          active[k]   = 1'b0;
          had_prev[k] = 1'b0;
        end else begin
          if (had_prev[k] && !prev_en[k]) begin
            total++;
            if (sig[k] !== prev_sig[k]) begin
              bad++;
              $display("FAIL hold_en0 dut%0d: got %h, need %h", k, sig[k], prev_sig[k]);
            end
          end else if (active[k]) begin
            cyc[k]++;
            if (ld_a_w[k]) begin
              nlda[k]++;
              last_lda[k] = cyc[k];
              if (sel1_w[k] == 2'b01 && nit[k] < 16) begin
                seq[k][nit[k]] = lock1_w[k];
                nit[k]++;
              end
            end
            if (ld_r_w[k]) begin
              nldr[k]++;
              total++;
              if (cyc[k] - last_lda[k] !== lat_of(k)) begin
                bad++;
                $display("FAIL ld_r_phase dut%0d: got %0d, need %0d", k, cyc[k] - last_lda[k], lat_of(k));
              end
            end
            if (eoc_w[k]) begin
              active[k] = 1'b0;
              total++;
              if (sbq.size() == 0) begin
                bad++;
                $display("FAIL eoc_unexpected dut%0d: got eoc, need no pending run", k);
              end else begin
                x = sbq.pop_front();
                if (x.dut !== k) begin
                  bad++;
                  $display("FAIL eoc_dut: got dut%0d, need dut%0d", k, x.dut);
                end
                total++;
                if (cyc[k] !== x.cyc) begin
                  bad++;
                  $display("FAIL latency dut%0d: got %0d, need %0d", k, cyc[k], x.cyc);
                end
                total++;
                if (nlda[k] !== x.nld || nldr[k] !== x.nld) begin
                  bad++;
                  $display("FAIL ld_count dut%0d: got ld_a=%0d ld_r=%0d, need %0d", k, nlda[k], nldr[k], x.nld);
                end
                total++;
                if (nit[k] !== x.nit || seq[k] !== x.seq) begin
                  bad++;
                  $display("FAIL lock1_seq dut%0d: got n=%0d %h, need n=%0d %h", k, nit[k], seq[k], x.nit, x.seq);
                end
              end
            end
          end else if (eoc_w[k]) begin
            total++;
            bad++;
            $display("FAIL eoc_idle dut%0d: got eoc=1, need 0", k);
          end
          if (!busy_w[k] && start_s[k] && en_s[k]) begin
            active[k]   = 1'b1;
            cyc[k]      = 0;
            nlda[k]     = 0;
            nldr[k]     = 0;
            nit[k]      = 0;
            last_lda[k] = 0;
            seq[k]      = 16'h0000;
          end
          prev_en[k]  = en_s[k];
          prev_sig[k] = sig[k];
          had_prev[k] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(int k, logic [7:0] e);
    case (k)
      0:       exp0_s = e;
      1:       exp1_s = e;
      default: exp2_s = e[3:0];
    endcase
  endtask

  task automatic launch(int k, logic [7:0] e);
    sbq.push_back(model(k, e));
    set_exp(k, e);
    start_s[k] = 1'b1;
    tick();
    start_s[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy_w[k]) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL timeout dut%0d: got no completion in %0d cycles, need eoc", k, budget);
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rstb    = 1'b0;
    en_s    = 3'b111;
    start_s = 3'b000;
    exp0_s  = 8'h00;
    exp1_s  = 8'h00;
    exp2_s  = 4'h0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sig[k] !== 10'h030) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %h, need %h", k, sig[k], 10'h030);
      end
    end
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_full_scan();
    logic [7:0] pats [4] = '{8'hA5, 8'hFF, 8'h00, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      launch(0, pats[i]);
      wait_done(0, 300);
      tick();
    end
  endtask

  task automatic test_early_exit();
    logic [7:0] pats [4] = '{8'h03, 8'h00, 8'h80, 8'h10};
    for (int i = 0; i < 4; i++) begin
      launch(1, pats[i]);
      wait_done(1, 300);
      tick();
    end
  endtask

  task automatic test_enable();
    int n = 0;
    launch(0, 8'hA5);
    while ((sbq.size() != 0 || busy_w[0]) && n < 600) begin
      en_s[0] = ~en_s[0];
      tick();
      n++;
    end
    en_s[0] = 1'b1;
    total++;
    if (n >= 600) begin
      bad++;
      $display("FAIL timeout_en dut0: got no completion in %0d cycles, need eoc", n);
      sbq.delete();
    end
    tick();
  endtask

  task automatic test_busy_start();
    int n = 0;
    launch(0, 8'hA5);
    repeat (48) tick();
    exp0_s     = 8'h00;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    total++;
    if (busy_w[0] !== 1'b1 || sel1_w[0] !== 2'b01) begin
      bad++;
      $display("FAIL busy_restart: got busy=%b sel1=%b, need 1/01", busy_w[0], sel1_w[0]);
    end
    wait_done(0, 300);
    tick();
    // start held high across eoc must relaunch once the pulse is over
    sbq.push_back(model(0, 8'h3C));
    sbq.push_back(model(0, 8'h3C));
    exp0_s     = 8'h3C;
    start_s[0] = 1'b1;
    tick();
    while (!eoc_w[0] && n < 300) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL relaunch_idle: got busy=%b, need 0", busy_w[0]);
    end
    tick();
    start_s[0] = 1'b0;
    total++;
    if (busy_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL relaunch_busy: got busy=%b, need 1", busy_w[0]);
    end
    wait_done(0, 300);
    tick();
  endtask

  task automatic test_reset_abort();
    launch(0, 8'hA5);
    repeat (41) tick();
    total++;
    if (sel1_w[0] !== 2'b01 || busy_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_setup: got sel1=%b busy=%b, need 01/1", sel1_w[0], busy_w[0]);
    end
    #2;
    rstb = 1'b0;
    #1;
    total++;
    if (sig[0] !== 10'h030) begin
      bad++;
      $display("FAIL abort_outputs: got %h, need %h", sig[0], 10'h030);
    end
    void'(sbq.pop_back());
    tick();
    tick();
    rstb = 1'b1;
    tick();
    launch(0, 8'hA5);
    wait_done(0, 300);
    tick();
  endtask

  task automatic test_small();
    logic [7:0] pats [2] = '{8'h0F, 8'h06};
    for (int i = 0; i < 2; i++) begin
      launch(2, pats[i]);
      wait_done(2, 200);
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_scan();
    test_early_exit();
    test_enable();
    test_busy_start();
    test_reset_abort();
    test_small();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
